systolic_sequencer: RTL

Control block that sequences one N×N matrix multiply through the systolic array. On a `start` handshake it issues skewed read addresses for the row (A) and column (B) operand memories, one lane per array edge input. It gates each lane with a valid bit so idle lanes feed zero, waits for the array pipeline to drain, then pulses `done`. It sits between the NPU command logic and the operand memories/array, replacing the free-running counter logic in the NPU top.

---
 rtl/npu_pkg.sv | 23 ++
 rtl/systolic_sequencer_if.sv | 30 +++
 rtl/seq_lane_gen.sv | 36 +++
 rtl/systolic_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU types and defaults: sequencer state encoding, array geometry,
// and the operand address helper used by every lane generator.
package npu_pkg;

  localparam int NPU_N         = 3;
  localparam int NPU_ADDR_W    = 5;
  localparam int NPU_DRAIN_CYC = 6;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } seq_state_e;

  function automatic logic [31:0] lane_addr(input logic [31:0] base,
                                            input logic [31:0] major,
                                            input logic [31:0] minor,
                                            input logic [31:0] n);
    return base + major * n + minor;
  endfunction

endpackage

// File: rtl/systolic_sequencer_if.sv
// Command/operand-address bundle between NPU command logic (master) and the
// systolic sequencer (slave).
interface systolic_sequencer_if #(
  parameter int N      = 3,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) ();

  logic                  start;
  logic [ADDR_W-1:0]     a_base;
  logic [ADDR_W-1:0]     b_base;
  logic                  busy;
  logic                  done;
  logic                  acc_clr;
  logic [N-1:0]          lane_vld;
  logic [N*ADDR_W-1:0]   a_addr;
  logic [N*ADDR_W-1:0]   b_addr;
  logic [CNT_W-1:0]      cyc_cnt;

  modport master (
    output start, a_base, b_base,
    input  busy, done, acc_clr, lane_vld, a_addr, b_addr, cyc_cnt
  );

  modport slave (
    input  start, a_base, b_base,
    output busy, done, acc_clr, lane_vld, a_addr, b_addr, cyc_cnt
  );

endinterface

// File: rtl/seq_lane_gen.sv
// Per-lane skewed address generator: lane K is live for feed steps K..K+N-1
// and forces its addresses to zero otherwise.
module seq_lane_gen
  import npu_pkg::*;
#(
  parameter int N      = NPU_N,
  parameter int ADDR_W = NPU_ADDR_W,
  parameter int K      = 0,
  parameter int T_W    = 3
) (
  input  logic              feed,
  input  logic [T_W-1:0]    t,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic              vld,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr
);

  logic [31:0]       t32;
  logic [31:0]       k32;
  logic [ADDR_W-1:0] a_mod;
  logic [ADDR_W-1:0] b_mod;

  always_comb begin
    t32    = 32'(t);
    k32    = 32'(K);
    vld    = feed && (t32 >= k32) && (t32 <= k32 + 32'(N) - 32'd1);
    // Truncation to ADDR_W gives the modulo-2^ADDR_W wrap for free.
    a_mod  = ADDR_W'(lane_addr(32'(a_base), k32, t32 - k32, 32'(N)));
    b_mod  = ADDR_W'(lane_addr(32'(b_base), t32 - k32, k32, 32'(N)));
    a_addr = vld ? a_mod : '0;
    b_addr = vld ? b_mod : '0;
  end

endmodule

// File: rtl/systolic_sequencer.sv
// Sequences one NxN systolic matrix multiply: skewed operand feed, drain, done.
// Optional busy-cycle counter enabled by defining SYSTOLIC_SEQ_PERF_EN.
module systolic_sequencer
  import npu_pkg::*;
#(
  parameter int N         = NPU_N,
  parameter int ADDR_W    = NPU_ADDR_W,
  parameter int DRAIN_CYC = NPU_DRAIN_CYC,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_sequencer_if.slave  bus
);

  localparam int T_W = (N > 1) ? $clog2(2 * N) : 1;
  localparam int D_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  seq_state_e            state_q, state_d;
  logic [T_W-1:0]        t_q, t_d;
  logic [D_W-1:0]        drain_q, drain_d;
  logic [ADDR_W-1:0]     a_base_q, a_base_d;
  logic [ADDR_W-1:0]     b_base_q, b_base_d;
  logic                  start_acc;
  logic                  feed_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  acc_clr_q, acc_clr_d;
  logic [N-1:0]          lane_vld_q, lane_vld_d;
  logic [N*ADDR_W-1:0]   a_addr_q, a_addr_d;
  logic [N*ADDR_W-1:0]   b_addr_q, b_addr_d;

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    drain_d   = drain_q;
    a_base_d  = a_base_q;
    b_base_d  = b_base_q;
    start_acc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          start_acc = 1'b1;
          state_d   = FEED;
          t_d       = '0;
          drain_d   = '0;
          a_base_d  = bus.a_base;
          b_base_d  = bus.b_base;
        end
      end
      FEED: begin
        if (t_q == T_W'(2 * N - 2)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == D_W'(DRAIN_CYC - 1)) state_d = DONE;
        else                                drain_d = drain_q + D_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from next state so the flops present them in the
    // same cycle the state register enters that state.
    feed_d    = (state_d == FEED);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    acc_clr_d = feed_d && (t_d == '0);
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    seq_lane_gen #(
      .N      (N),
      .ADDR_W (ADDR_W),
      .K      (k),
      .T_W    (T_W)
    ) u_lane (
      .feed   (feed_d),
      .t      (t_d),
      .a_base (a_base_d),
      .b_base (b_base_d),
      .vld    (lane_vld_d[k]),
      .a_addr (a_addr_d[k*ADDR_W +: ADDR_W]),
      .b_addr (b_addr_d[k*ADDR_W +: ADDR_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      t_q        <= '0;
      drain_q    <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_clr_q  <= 1'b0;
      lane_vld_q <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      drain_q    <= drain_d;
      a_base_q   <= a_base_d;
      b_base_q   <= b_base_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      acc_clr_q  <= acc_clr_d;
      lane_vld_q <= lane_vld_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.acc_clr  = acc_clr_q;
  assign bus.lane_vld = lane_vld_q;
  assign bus.a_addr   = a_addr_q;
  assign bus.b_addr   = b_addr_q;

`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_acc)                             cnt_d = '0;
    else if (state_q != IDLE && cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign bus.cyc_cnt = cnt_q;
`else
  assign bus.cyc_cnt = {CNT_W{1'b0}};
`endif

endmodule
